mem_arbiter: RTL

- Shares the core's single-port unified memory between the instruction-fetch port and the load/store data port.
- Accepts one request per transaction and drives the memory command.
- Tracks read latency, then returns read data to the requester that issued the read.
- Sits between the Core pipeline stages and the memory instance.

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch port and the load/store port.
// Build option MEM_ARB_RR_EN selects round-robin arbitration; otherwise data has fixed priority.
module mem_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int CW = 3;
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [1:0]    owner_r, owner_s;
    logic [DW-1:0] if_hold_r, d_hold_r;
    logic          pick_d_s;
    logic          rd_gnt_s;
    logic          rv_s;
`ifdef MEM_ARB_RR_EN
    logic          last_d_r;
`endif

    // State, latency counter, owner, held read data and arbitration history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            owner_r   <= OWN_NONE;
            if_hold_r <= {DW{1'b0}};
            d_hold_r  <= {DW{1'b0}};
`ifdef MEM_ARB_RR_EN
            last_d_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            owner_r <= owner_s;
            if (if_rvalid) begin
                if_hold_r <= mem_rdata;
            end
            if (d_rvalid) begin
                d_hold_r <= mem_rdata;
            end
`ifdef MEM_ARB_RR_EN
            if (if_gnt || d_gnt) begin
                last_d_r <= d_gnt;
            end
`endif
        end
    end

    // Arbitration: decide whether the data port wins this cycle.
    always_comb begin
        pick_d_s = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (d_req && if_req) begin
            pick_d_s = !last_d_r;
        end else begin
            pick_d_s = d_req;
        end
`else
        pick_d_s = d_req;
`endif
    end

    // Grants and memory command, combinational from the winner while idle.
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        if (rst && (state_r == IDLE)) begin
            if (pick_d_s) begin
                d_gnt     = 1'b1;
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_be    = d_we ? d_be : 4'hF;
                mem_addr  = d_addr;
                mem_wdata = d_we ? d_wdata : {DW{1'b0}};
            end else if (if_req) begin
                if_gnt   = 1'b1;
                mem_en   = 1'b1;
                mem_be   = 4'hF;
                mem_addr = if_addr;
            end else begin
                mem_en = 1'b0;
            end
        end else begin
            mem_en = 1'b0;
        end
    end

    // Read response: pulse on the last latency cycle and pass memory data straight through.
    always_comb begin
        rv_s      = rst && (state_r == WAIT) && (cnt_r == CW'(1));
        if_rvalid = rv_s && (owner_r == OWN_IF);
        d_rvalid  = rv_s && (owner_r == OWN_D);
        if_rdata  = if_rvalid ? mem_rdata : if_hold_r;
        d_rdata   = d_rvalid ? mem_rdata : d_hold_r;
    end

    // Next state: reads park the arbiter in WAIT until the counter runs out.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        owner_s  = owner_r;
        rd_gnt_s = if_gnt || (d_gnt && !d_we);
        case (state_r)
            IDLE: begin
                if (rd_gnt_s) begin
                    state_s = WAIT;
                    cnt_s   = CW'(RD_LAT);
                    owner_s = if_gnt ? OWN_IF : OWN_D;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r <= CW'(1)) begin
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                    owner_s = OWN_NONE;
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
                owner_s = OWN_NONE;
            end
        endcase
    end
endmodule
